fetch_ctrl: RTL and testbench

Fetch/decode/interrupt sequencer for the basic CPU. Consumes the one-hot timing signals T0–T15 from the timing generator and produces the bus-select and register-load strobes for instruction fetch, instruction decode and the interrupt cycle. It holds the instruction register, the decoded opcode lines D0–D7, the indirect bit I, and the interrupt flip-flops R and IEN. Execute-phase micro-operations belong to the downstream execute block, which is enabled by `exec`.

---
 rtl/fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Fetch/decode/interrupt sequencer for the basic CPU. Decodes the
//             one-hot timing slots into datapath strobes and holds IR, D0-D7,
//             I, R and IEN. Optional interrupt logic: define INTERRUPT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] t,
    input  logic [15:0] mem_data,
    input  logic        fgi,
    input  logic        fgo,
    input  logic        ien_set,
    input  logic        ien_clr,
    output logic [2:0]  bus_sel,
    output logic        ld_ar,
    output logic        clr_ar,
    output logic        ld_ir,
    output logic        inc_pc,
    output logic        clr_pc,
    output logic        ld_tr,
    output logic        rd_mem,
    output logic        wr_mem,
    output logic [15:0] ir,
    output logic [7:0]  d,
    output logic        i_bit,
    output logic        r_flag,
    output logic        ien,
    output logic        exec,
    output logic        sc_clr
);

    localparam logic [2:0] C_BUS_NONE = 3'd0;
    localparam logic [2:0] C_BUS_PC   = 3'd2;
    localparam logic [2:0] C_BUS_IR   = 3'd5;
    localparam logic [2:0] C_BUS_TR   = 3'd6;
    localparam logic [2:0] C_BUS_MEM  = 3'd7;

    logic        w_t_onehot;
    logic        w_t0;
    logic        w_t1;
    logic        w_t2;
    logic        w_t_exec;
    logic        w_ld_dec;
    logic [7:0]  w_dec;
    logic [15:0] r_ir;
    logic [7:0]  r_d;
    logic        r_i;

    // A malformed timing word (none or several slots) must not move anything.
    assign w_t_onehot = (t != 16'd0) && ((t & (t - 16'd1)) == 16'd0);
    assign w_t0       = w_t_onehot & t[0];
    assign w_t1       = w_t_onehot & t[1];
    assign w_t2       = w_t_onehot & t[2];
    assign w_t_exec   = w_t_onehot & (|t[15:3]);

    always_comb begin
        bus_sel = C_BUS_NONE;
        ld_ar   = 1'b0;
        clr_ar  = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        clr_pc  = 1'b0;
        ld_tr   = 1'b0;
        rd_mem  = 1'b0;
        wr_mem  = 1'b0;
        sc_clr  = 1'b0;
        exec    = w_t_exec & ~r_flag;
        if (!r_flag) begin
            if (w_t0) begin
                bus_sel = C_BUS_PC;
                ld_ar   = 1'b1;
            end else if (w_t1) begin
                bus_sel = C_BUS_MEM;
                rd_mem  = 1'b1;
                ld_ir   = 1'b1;
                inc_pc  = 1'b1;
            end else if (w_t2) begin
                bus_sel = C_BUS_IR;
                ld_ar   = 1'b1;
            end
        end
`ifdef INTERRUPT_EN
        else begin
            // Save PC to address 0, then continue at address 1.
            if (w_t0) begin
                clr_ar  = 1'b1;
                bus_sel = C_BUS_PC;
                ld_tr   = 1'b1;
            end else if (w_t1) begin
                bus_sel = C_BUS_TR;
                wr_mem  = 1'b1;
                clr_pc  = 1'b1;
            end else if (w_t2) begin
                inc_pc  = 1'b1;
                sc_clr  = 1'b1;
            end
        end
`endif
    end

    assign w_ld_dec = w_t2 & ~r_flag;
    assign w_dec    = 8'h01 << r_ir[14:12];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir <= 16'd0;
            r_d  <= 8'h01;
            r_i  <= 1'b0;
        end else begin
            if (ld_ir) begin
                r_ir <= mem_data;
            end
            if (w_ld_dec) begin
                r_d <= w_dec;
                r_i <= r_ir[15];
            end
        end
    end

    assign ir    = r_ir;
    assign d     = r_d;
    assign i_bit = r_i;

`ifdef INTERRUPT_EN
    logic r_r;
    logic r_ien;
    logic w_r_set;
    logic w_int_end;

    // R may only rise outside the fetch slots so an instruction is never split.
    assign w_r_set   = ~r_r & r_ien & (fgi | fgo) & w_t_exec;
    assign w_int_end = r_r & w_t2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_r   <= 1'b0;
            r_ien <= 1'b0;
        end else begin
            if (w_int_end) begin
                r_r <= 1'b0;
            end else if (w_r_set) begin
                r_r <= 1'b1;
            end
            if (w_int_end) begin
                r_ien <= 1'b0;
            end else if (w_t_onehot) begin
                if (ien_clr) begin
                    r_ien <= 1'b0;
                end else if (ien_set) begin
                    r_ien <= 1'b1;
                end
            end
        end
    end

    assign r_flag = r_r;
    assign ien    = r_ien;
`else
    logic w_unused_irq;

    assign w_unused_irq = fgi ^ fgo ^ ien_set ^ ien_clr;
    assign r_flag       = 1'b0;
    assign ien          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Purpose  : Directed vector table plus hand sequences for fetch_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] t;
    logic [15:0] mem_data;
    logic        fgi, fgo, ien_set, ien_clr;
    logic [2:0]  bus_sel;
    logic        ld_ar, clr_ar, ld_ir, inc_pc, clr_pc, ld_tr, rd_mem, wr_mem;
    logic [15:0] ir;
    logic [7:0]  d;
    logic        i_bit, r_flag, ien, exec, sc_clr;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .t(t), .mem_data(mem_data),
        .fgi(fgi), .fgo(fgo), .ien_set(ien_set), .ien_clr(ien_clr),
        .bus_sel(bus_sel), .ld_ar(ld_ar), .clr_ar(clr_ar), .ld_ir(ld_ir),
        .inc_pc(inc_pc), .clr_pc(clr_pc), .ld_tr(ld_tr), .rd_mem(rd_mem),
        .wr_mem(wr_mem), .ir(ir), .d(d), .i_bit(i_bit), .r_flag(r_flag),
        .ien(ien), .exec(exec), .sc_clr(sc_clr)
    );

    localparam logic [9:0] LDAR = 10'h200, CLAR = 10'h100, LDIR = 10'h080,
                           INPC = 10'h040, CLPC = 10'h020, LDTR = 10'h010,
                           RDM  = 10'h008, WRM  = 10'h004, SCC  = 10'h002,
                           EXE  = 10'h001;

    logic [9:0] strb;
    assign strb = {ld_ar, clr_ar, ld_ir, inc_pc, clr_pc, ld_tr, rd_mem, wr_mem, sc_clr, exec};

    typedef struct {
        logic [15:0] t;
        logic [15:0] mem;
        logic        fgi, fgo, iset, iclr;
        logic [2:0]  bus;
        logic [9:0]  strb;
        logic [15:0] ir;
        logic [7:0]  d;
        logic        ib, rf, ien;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] ts(input int k);
        return 16'h0001 << k;
    endfunction

    function automatic vec_t mk(input logic [15:0] tv, input logic [15:0] mem,
                                input logic fi, input logic fo, input logic is, input logic ic,
                                input logic [2:0] bus, input logic [9:0] sb,
                                input logic [15:0] irv, input logic [7:0] dv,
                                input logic ib, input logic rf, input logic ie);
        vec_t v;
        v.t = tv; v.mem = mem; v.fgi = fi; v.fgo = fo; v.iset = is; v.iclr = ic;
        v.bus = bus; v.strb = sb; v.ir = irv; v.d = dv; v.ib = ib; v.rf = rf; v.ien = ie;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] irv, input logic [7:0] dv,
                               input logic ib, input logic rf, input logic ie);
        n_vec++;
        chk({tag, " ir"}, 32'(ir), 32'(irv));
        chk({tag, " d"}, 32'(d), 32'(dv));
        chk({tag, " i_bit"}, 32'(i_bit), 32'(ib));
        chk({tag, " r_flag"}, 32'(r_flag), 32'(rf));
        chk({tag, " ien"}, 32'(ien), 32'(ie));
    endtask

    task automatic check_strobes(input string tag, input logic [2:0] bus, input logic [9:0] sb);
        n_vec++;
        chk({tag, " bus_sel"}, 32'(bus_sel), 32'(bus));
        chk({tag, " strobes"}, 32'(strb), 32'(sb));
    endtask

    task automatic drive(input logic [15:0] tv, input logic [15:0] mem,
                         input logic fi, input logic fo, input logic is, input logic ic);
        t = tv; mem_data = mem; fgi = fi; fgo = fo; ien_set = is; ien_clr = ic;
    endtask

    logic exp_rf_mid;

    initial begin
`ifdef INTERRUPT_EN
        tbl.push_back(mk(ts(0), 16'h9123, 0, 0, 1, 1, 3'd2, LDAR,             16'h0000, 8'h01, 0, 0, 0));
        tbl.push_back(mk(ts(1), 16'h9123, 0, 0, 1, 0, 3'd7, RDM|LDIR|INPC,    16'h0000, 8'h01, 0, 0, 0));
        tbl.push_back(mk(ts(2), 16'h0000, 0, 1, 0, 0, 3'd5, LDAR,             16'h9123, 8'h01, 0, 0, 1));
        tbl.push_back(mk(ts(3), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'h9123, 8'h02, 1, 0, 1));
        tbl.push_back(mk(ts(4), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'h9123, 8'h02, 1, 0, 1));
        tbl.push_back(mk(ts(5), 16'h0000, 1, 0, 0, 0, 3'd0, EXE,              16'h9123, 8'h02, 1, 0, 1));
        tbl.push_back(mk(ts(0), 16'h0000, 0, 0, 0, 0, 3'd2, CLAR|LDTR,        16'h9123, 8'h02, 1, 1, 1));
        tbl.push_back(mk(ts(1), 16'h0000, 0, 0, 0, 0, 3'd6, WRM|CLPC,         16'h9123, 8'h02, 1, 1, 1));
        tbl.push_back(mk(ts(2), 16'h0000, 0, 0, 1, 0, 3'd0, INPC|SCC,         16'h9123, 8'h02, 1, 1, 1));
        tbl.push_back(mk(ts(0), 16'h1234, 0, 0, 0, 0, 3'd2, LDAR,             16'h9123, 8'h02, 1, 0, 0));
        tbl.push_back(mk(ts(1), 16'h1234, 0, 1, 1, 0, 3'd7, RDM|LDIR|INPC,    16'h9123, 8'h02, 1, 0, 0));
        tbl.push_back(mk(ts(2), 16'h0000, 0, 1, 0, 0, 3'd5, LDAR,             16'h1234, 8'h02, 1, 0, 1));
        tbl.push_back(mk(ts(3), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'h1234, 8'h02, 0, 0, 1));
        tbl.push_back(mk(ts(0), 16'h4321, 0, 1, 0, 0, 3'd2, LDAR,             16'h1234, 8'h02, 0, 0, 1));
        tbl.push_back(mk(ts(1), 16'h4321, 0, 1, 0, 0, 3'd7, RDM|LDIR|INPC,    16'h1234, 8'h02, 0, 0, 1));
        tbl.push_back(mk(ts(2), 16'h0000, 0, 1, 0, 0, 3'd5, LDAR,             16'h4321, 8'h02, 0, 0, 1));
        tbl.push_back(mk(ts(3), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'h4321, 8'h10, 0, 0, 1));
        tbl.push_back(mk(16'h0003, 16'hFFFF, 1, 0, 0, 0, 3'd0, 10'h000,       16'h4321, 8'h10, 0, 0, 1));
        tbl.push_back(mk(ts(4), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'h4321, 8'h10, 0, 0, 1));
        exp_rf_mid = 1'b1;
`else
        tbl.push_back(mk(ts(0), 16'h9123, 0, 0, 0, 0, 3'd2, LDAR,             16'h0000, 8'h01, 0, 0, 0));
        tbl.push_back(mk(ts(1), 16'h9123, 0, 0, 0, 0, 3'd7, RDM|LDIR|INPC,    16'h0000, 8'h01, 0, 0, 0));
        tbl.push_back(mk(ts(2), 16'hFFFF, 0, 0, 0, 0, 3'd5, LDAR,             16'h9123, 8'h01, 0, 0, 0));
        tbl.push_back(mk(ts(3), 16'h0000, 1, 0, 1, 0, 3'd0, EXE,              16'h9123, 8'h02, 1, 0, 0));
        tbl.push_back(mk(ts(4), 16'h0000, 1, 1, 1, 0, 3'd0, EXE,              16'h9123, 8'h02, 1, 0, 0));
        tbl.push_back(mk(ts(0), 16'h2ABC, 1, 0, 0, 0, 3'd2, LDAR,             16'h9123, 8'h02, 1, 0, 0));
        tbl.push_back(mk(ts(1), 16'h2ABC, 0, 0, 0, 0, 3'd7, RDM|LDIR|INPC,    16'h9123, 8'h02, 1, 0, 0));
        tbl.push_back(mk(ts(2), 16'h0000, 0, 0, 0, 0, 3'd5, LDAR,             16'h2ABC, 8'h02, 1, 0, 0));
        tbl.push_back(mk(16'h0003, 16'hFFFF, 0, 0, 0, 0, 3'd0, 10'h000,       16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(16'h0000, 16'hFFFF, 0, 0, 0, 0, 3'd0, 10'h000,       16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(16'h8000, 16'hFFFF, 0, 0, 0, 0, 3'd0, EXE,           16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(16'h0006, 16'hFFFF, 0, 0, 0, 0, 3'd0, 10'h000,       16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(ts(3), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(ts(0), 16'hF000, 0, 0, 0, 0, 3'd2, LDAR,             16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(ts(1), 16'hF000, 0, 0, 0, 0, 3'd7, RDM|LDIR|INPC,    16'h2ABC, 8'h04, 0, 0, 0));
        tbl.push_back(mk(ts(2), 16'h0000, 0, 0, 0, 0, 3'd5, LDAR,             16'hF000, 8'h04, 0, 0, 0));
        tbl.push_back(mk(ts(3), 16'h0000, 0, 0, 0, 0, 3'd0, EXE,              16'hF000, 8'h80, 1, 0, 0));
        exp_rf_mid = 1'b0;
`endif

        reset = 1'b0;
        drive(16'h0000, 16'h0000, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_state("reset", 16'h0000, 8'h01, 0, 0, 0);
        check_strobes("reset", 3'd0, 10'h000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].t, tbl[i].mem, tbl[i].fgi, tbl[i].fgo, tbl[i].iset, tbl[i].iclr);
            #1;
            check_strobes($sformatf("v%0d", i), tbl[i].bus, tbl[i].strb);
            check_state($sformatf("v%0d", i), tbl[i].ir, tbl[i].d, tbl[i].ib, tbl[i].rf, tbl[i].ien);
        end

        // Raise R in T4, then pull reset mid-slot in T5.
        @(negedge clk);
        drive(ts(4), 16'h0000, 1, 0, 0, 0);
        @(negedge clk);
        drive(ts(5), 16'h0000, 0, 0, 0, 0);
        #1;
        n_vec++;
        chk("pre-reset r_flag", 32'(r_flag), 32'(exp_rf_mid));
        #1;
        reset = 1'b0;
        #1;
        check_state("async reset", 16'h0000, 8'h01, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(ts(0), 16'h0000, 0, 0, 0, 0);
        #1;
        check_strobes("restart T0", 3'd2, LDAR);
        check_state("restart T0", 16'h0000, 8'h01, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
